ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable).
- Companion to the keyboard receive path.
- Drives the open-drain kbd_clk/kbd_data lines through active-low drive enables and checks the device acknowledge.
- Sits between the CPU I/O bus register and the PS/2 pads. The receive path must ignore traffic while tx_busy is high.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles kbd_clk is held low before request-to-send (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max clk cycles allowed between request-to-send and the first device clock edge, and between consecutive edges (15 ms at 50 MHz)
CNT_W, 20, width of the shared cycle counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tx_data  in  8  command byte
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high when idle; a byte is accepted on a cycle where tx_valid & tx_ready
tx_busy  out  1  high from accept until done or error
done_pulse  out  1  one-cycle pulse: byte sent and ACK received
error_pulse  out  1  one-cycle pulse: timeout or missing ACK
kbd_clk  in  1  PS/2 clock pad input (asynchronous)
kbd_data  in  1  PS/2 data pad input (asynchronous)
kbd_clk_drive_low  out  1  1 = pull clock line low, 0 = release
kbd_data_drive_low  out  1  1 = pull data line low, 0 = release

Behaviour:
- Reset, applied at any time including mid-frame:
  - state=IDLE, tx_ready=1, tx_busy=0, both drive_low=0, pulses=0, counters=0.
  - Lines are released on the first clk edge with reset high.
- Pad sync: kbd_clk and kbd_data each pass through a 2-FF synchronizer. fall = previous synced clk 1 and current 0. All protocol decisions use synced values; effective latency is 2 cycles.
- Frame to send: start 0 (the request-to-send), data[0..7] LSB first, odd parity (~^data), stop 1. The device then clocks an ACK (data low).
- Parity is computed from the latched byte at accept. tx_data may change afterwards.
- IDLE:
  - tx_ready=1. On accept, latch the byte and go to INHIBIT.
  - tx_valid while busy is ignored; no queueing.
- INHIBIT: kbd_clk_drive_low=1 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: in the same cycle, kbd_data_drive_low=1 and kbd_clk_drive_low=0. Start the timeout counter and set bit index=0.
- SEND:
  - Falls 1-8: on each fall, set kbd_data_drive_low = ~data[idx] on the next cycle, then idx++.
  - Fall 9: drive ~parity.
  - Fall 10: release data (stop bit 1).
  - The timeout counter reloads on every fall.
- ACK: on fall 11, sample synced kbd_data.
  - 0: go to WAIT_IDLE.
  - 1: error_pulse, go to IDLE.
- WAIT_IDLE: wait until synced kbd_clk=1 and kbd_data=1, then done_pulse=1 for one cycle, go to IDLE. This state is subject to the same timeout.
- Timeout: the counter reaching TIMEOUT_CYCLES in RTS, SEND, ACK or WAIT_IDLE:
  - release both lines immediately;
  - error_pulse for one cycle;
  - go to IDLE.
- tx_busy = state != IDLE. done_pulse and error_pulse are mutually exclusive and never asserted in IDLE-with-accept cycles.
- A fall seen in INHIBIT (device glitch) is ignored.
- The host never drives either line high.

Optional Feature:
- PS2_TX_RETRY_EN defined: a missing ACK or a timeout restarts the frame from INHIBIT with the same byte, up to 2 retries.
  - error_pulse fires only after the 3rd failure.
  - A retry counter (2 bits) clears on accept.
- Undefined: the first failure ends the frame with error_pulse. No retry counter exists.

Decomposition:
- ps2_pkg holds:
  - state enum {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE};
  - PS2_FRAME_FALLS=11;
  - default timing constants;
  - PS2_TX_MAX_RETRY=2.
- One sub-module, ps2_line_sync: 2-FF synchronizers for clk/data plus the falling-edge detector. The keyboard receive path reuses it.

Test Plan:
Bench parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200. A device BFM generates 11 clock periods of 40 cycles, samples data on rising edges and drives the ACK.
- Send 0xED -> clk held low for 20 cycles, then RTS. BFM reads bits 1,0,1,1,0,1,1,1 and parity 1, stop 1. BFM ACKs -> done_pulse once, tx_ready back high.
- Send 0x00 -> parity bit 1 observed. Send 0xFF -> parity bit 0 observed. Both end in done_pulse.
- BFM withholds ACK (data stays high on fall 11) -> error_pulse once, both drive_low=0, no done_pulse.
- BFM never clocks after RTS -> error_pulse exactly 200 cycles after RTS (+sync latency), lines released. With PS2_TX_RETRY_EN: 3 INHIBIT phases, then error_pulse.
- Reset asserted after fall 5 -> next cycle both drive_low=0, tx_busy=0, tx_ready=1. A following 0xF4 send completes normally.
- tx_valid held with 0xAA during a 0xED frame -> BFM decodes only 0xED, and 0xAA is not sent afterwards.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, frame constants and default timing
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SEND,
      ACK,
      WAIT_IDLE
   } ps2_tx_state_e;

   localparam int PS2_FRAME_FALLS        = 11;
   localparam int PS2_DEF_INHIBIT_CYCLES = 5000;
   localparam int PS2_DEF_TIMEOUT_CYCLES = 750000;
   localparam int PS2_DEF_CNT_W          = 20;
   localparam int PS2_TX_MAX_RETRY       = 2;

   function automatic logic ps2_odd_parity(input logic [7:0] i_byte);
      return ~^i_byte;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF pad synchronizers for kbd_clk/kbd_data plus falling-edge detect
module ps2_line_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_kbd_clk,
   input  logic i_kbd_data,
   output logic o_clk_sync,
   output logic o_data_sync,
   output logic o_clk_fall
);

   logic r_clk_s1;
   logic r_clk_s2;
   logic r_clk_prev;
   logic r_data_s1;
   logic r_data_s2;

   // Idle lines float high, so reset to 1 to avoid a phantom fall after reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_data_s1  <= 1'b1;
         r_data_s2  <= 1'b1;
      end else begin
         r_clk_s1   <= i_kbd_clk;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_data_s1  <= i_kbd_data;
         r_data_s2  <= r_data_s1;
      end
   end

   assign o_clk_sync  = r_clk_s2;
   assign o_data_sync = r_data_s2;
   assign o_clk_fall  = r_clk_prev & ~r_clk_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (optional retry: PS2_TX_RETRY_EN)
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = PS2_DEF_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = PS2_DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = PS2_DEF_CNT_W
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready,
   output logic       o_tx_busy,
   output logic       o_done_pulse,
   output logic       o_error_pulse,
   input  logic       i_kbd_clk,
   input  logic       i_kbd_data,
   output logic       o_kbd_clk_drive_low,
   output logic       o_kbd_data_drive_low
);

   localparam logic [CNT_W-1:0] LP_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [3:0]       LP_PAR_IDX  = 4'(PS2_FRAME_FALLS - 3);
   localparam logic [3:0]       LP_STOP_IDX = 4'(PS2_FRAME_FALLS - 2);

   ps2_tx_state_e    r_state;
   ps2_tx_state_e    w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [3:0]       r_idx;
   logic [3:0]       w_idx_nxt;
   logic [7:0]       r_byte;
   logic [7:0]       w_byte_nxt;
   logic             r_parity;
   logic             w_parity_nxt;
   logic             r_data_low;
   logic             w_data_low_nxt;
   logic             w_done;
   logic             w_error;
   logic             w_fail;
   logic             w_timeout;
   logic             w_clk_sync;
   logic             w_data_sync;
   logic             w_fall;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]       r_retry;
   logic [1:0]       w_retry_nxt;
`endif

   ps2_line_sync u_line_sync (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_kbd_clk   (i_kbd_clk),
      .i_kbd_data  (i_kbd_data),
      .o_clk_sync  (w_clk_sync),
      .o_data_sync (w_data_sync),
      .o_clk_fall  (w_fall)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_byte     <= '0;
         r_parity   <= 1'b0;
         r_data_low <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         r_retry    <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_byte     <= w_byte_nxt;
         r_parity   <= w_parity_nxt;
         r_data_low <= w_data_low_nxt;
`ifdef PS2_TX_RETRY_EN
         r_retry    <= w_retry_nxt;
`endif
      end
   end

   assign w_timeout = (r_cnt == LP_TIMEOUT);

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_idx_nxt      = r_idx;
      w_byte_nxt     = r_byte;
      w_parity_nxt   = r_parity;
      w_data_low_nxt = r_data_low;
      w_done         = 1'b0;
      w_error        = 1'b0;
      w_fail         = 1'b0;
`ifdef PS2_TX_RETRY_EN
      w_retry_nxt    = r_retry;
`endif
      case (r_state)
         IDLE: begin
            if (i_tx_valid) begin
               w_byte_nxt   = i_tx_data;
               w_parity_nxt = ps2_odd_parity(i_tx_data);
               w_cnt_nxt    = '0;
               w_state_nxt  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
               w_retry_nxt  = '0;
`endif
            end
         end
         INHIBIT: begin
            // Device clock falls here are glitches and deliberately ignored.
            if (r_cnt == LP_INH_LAST) begin
               w_cnt_nxt      = '0;
               w_idx_nxt      = '0;
               w_data_low_nxt = 1'b0;
               w_state_nxt    = RTS;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RTS: begin
            if (w_fall) begin
               w_data_low_nxt = ~r_byte[0];
               w_idx_nxt      = 4'd1;
               w_cnt_nxt      = '0;
               w_state_nxt    = SEND;
            end else if (w_timeout) begin
               w_fail = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         SEND: begin
            if (w_fall) begin
               w_cnt_nxt = '0;
               w_idx_nxt = r_idx + 4'd1;
               if (r_idx < LP_PAR_IDX) begin
                  w_data_low_nxt = ~r_byte[r_idx[2:0]];
               end else if (r_idx == LP_PAR_IDX) begin
                  w_data_low_nxt = ~r_parity;
               end else begin
                  w_data_low_nxt = 1'b0;
                  w_state_nxt    = ACK;
               end
            end else if (w_timeout) begin
               w_fail = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ACK: begin
            if (w_fall) begin
               w_cnt_nxt = '0;
               if (!w_data_sync) begin
                  w_state_nxt = WAIT_IDLE;
               end else begin
                  w_fail = 1'b1;
               end
            end else if (w_timeout) begin
               w_fail = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (w_clk_sync && w_data_sync) begin
               w_done      = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = IDLE;
            end else if (w_timeout) begin
               w_fail = 1'b1;
            end else if (w_fall) begin
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      if (w_fail) begin
         w_data_low_nxt = 1'b0;
         w_cnt_nxt      = '0;
         w_idx_nxt      = '0;
`ifdef PS2_TX_RETRY_EN
         if (r_retry < 2'(PS2_TX_MAX_RETRY)) begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = INHIBIT;
         end else begin
            w_error     = 1'b1;
            w_state_nxt = IDLE;
         end
`else
         w_error     = 1'b1;
         w_state_nxt = IDLE;
`endif
      end
   end

   assign o_tx_ready           = (r_state == IDLE);
   assign o_tx_busy            = (r_state != IDLE);
   assign o_done_pulse         = w_done;
   assign o_error_pulse        = w_error;
   assign o_kbd_clk_drive_low  = (r_state == INHIBIT);
   // Failing cycles drop the data line at once rather than a cycle later.
   assign o_kbd_data_drive_low = ((r_state == RTS) | ((r_state == SEND) & r_data_low)) & ~w_fail;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model and scoreboard
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TO   = 200;
   localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
   localparam int N_ATTEMPTS = 3;
`else
   localparam int N_ATTEMPTS = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_busy;
   logic       done_p;
   logic       err_p;
   logic       host_clk_low;
   logic       host_data_low;
   logic       bfm_clk_low = 1'b0;
   logic       bfm_data_low = 1'b0;
   logic       kbd_clk_line;
   logic       kbd_data_line;

   assign kbd_clk_line  = ~(host_clk_low | bfm_clk_low);
   assign kbd_data_line = ~(host_data_low | bfm_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (20)
   ) dut (
      .i_clk                (clk),
      .i_reset              (reset),
      .i_tx_data            (tx_data),
      .i_tx_valid           (tx_valid),
      .o_tx_ready           (tx_ready),
      .o_tx_busy            (tx_busy),
      .o_done_pulse         (done_p),
      .o_error_pulse        (err_p),
      .i_kbd_clk            (kbd_clk_line),
      .i_kbd_data           (kbd_data_line),
      .o_kbd_clk_drive_low  (host_clk_low),
      .o_kbd_data_drive_low (host_data_low)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_done = 0;
   int n_err = 0;
   int n_pass = 0;
   int n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (done_p) n_done <= n_done + 1;
      if (err_p)  n_err  <= n_err + 1;
   end

   typedef struct {
      logic [7:0] b;
      logic       p;
   } exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic wait_rts(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (host_data_low && !host_clk_low) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic bfm_frame(input bit ack, input bit drop_valid, input int n_periods,
                            output logic [10:0] rx);
      rx = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < n_periods; k++) begin
         if (k == 10 && drop_valid) tx_valid = 1'b0;
         bfm_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         bfm_clk_low = 1'b0;
         rx[k] = kbd_data_line;
         if (k == 9 && ack) bfm_data_low = 1'b1;
         if (k == 10) bfm_data_low = 1'b0;
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ack, input bit hold, input logic [7:0] hold_b);
      int         d0;
      int         e0;
      int         n;
      int         attempts;
      bit         ok;
      logic [10:0] rx;
      exp_t       e;
      attempts = ack ? 1 : N_ATTEMPTS;
      d0 = n_done;
      e0 = n_err;
      check("ready_before", tx_ready, 1);
      for (int a = 0; a < attempts; a++) sb.push_back('{b, ~^b});
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      if (hold) tx_data = hold_b;
      else tx_valid = 1'b0;
      n = 0;
      while (host_clk_low && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("inhibit_len", n, INH);
      for (int a = 0; a < attempts; a++) begin
         wait_rts(ok);
         check("rts_seen", ok, 1);
         bfm_frame(ack, hold, 11, rx);
         e = sb.pop_front();
         check("data_byte", rx[7:0], e.b);
         check("parity", rx[8], e.p);
         check("stop", rx[9], 1);
      end
      repeat (3) @(negedge clk);
      check("done_count", n_done - d0, ack ? 1 : 0);
      check("err_count", n_err - e0, ack ? 0 : 1);
      check("ready_after", tx_ready, 1);
      check("busy_after", tx_busy, 0);
      check("drives_after", {host_clk_low, host_data_low}, 0);
      if (hold) begin
         repeat (100) @(negedge clk);
         check("hold_no_resend", {tx_ready, host_clk_low, tx_busy}, 3'b100);
         check("sb_empty", sb.size(), 0);
      end
   endtask

   task automatic run_timeout(input logic [7:0] b);
      int  n_inh;
      int  rts_cyc;
      int  err_cyc;
      int  e0;
      bit  prev_clk_low;
      bit  prev_rts;
      bit  seen;
      e0 = n_err;
      n_inh = 0;
      rts_cyc = -1;
      err_cyc = -1;
      prev_clk_low = 1'b0;
      prev_rts = 1'b0;
      seen = 1'b0;
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (host_clk_low && !prev_clk_low) n_inh++;
         if (host_data_low && !host_clk_low && !prev_rts) rts_cyc = cyc;
         prev_clk_low = host_clk_low;
         prev_rts = host_data_low && !host_clk_low;
         if (err_p) begin
            err_cyc = cyc;
            seen = 1'b1;
            check("to_drives_at_err", {host_clk_low, host_data_low}, 0);
            break;
         end
         @(negedge clk);
      end
      check("to_error_seen", seen, 1);
      check("to_delay", err_cyc - rts_cyc, TO);
      check("to_inhibit_phases", n_inh, N_ATTEMPTS);
      repeat (3) @(negedge clk);
      check("to_err_count", n_err - e0, 1);
      check("to_drives_after", {host_clk_low, host_data_low}, 0);
      check("to_ready", tx_ready, 1);
   endtask

   initial begin
      bit          ok;
      logic [10:0] rx;
      repeat (3) @(negedge clk);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_clk_drive", host_clk_low, 0);
      check("rst_data_drive", host_data_low, 0);
      check("rst_pulses", {done_p, err_p}, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      run_frame(8'hED, 1'b1, 1'b0, 8'h00);
      run_frame(8'h00, 1'b1, 1'b0, 8'h00);
      run_frame(8'hFF, 1'b1, 1'b0, 8'h00);
      run_frame(8'hA5, 1'b0, 1'b0, 8'h00);
      run_timeout(8'h55);

      // Abort mid-frame with reset just after the fifth device clock fall.
      tx_data  = 8'h12;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_rts(ok);
      check("abort_rts_seen", ok, 1);
      bfm_frame(1'b0, 1'b0, 4, rx);
      bfm_clk_low = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_busy_before", tx_busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_drives", {host_clk_low, host_data_low}, 0);
      check("abort_busy", tx_busy, 0);
      check("abort_ready", tx_ready, 1);
      reset = 1'b0;
      bfm_clk_low = 1'b0;
      bfm_data_low = 1'b0;
      repeat (10) @(negedge clk);
      run_frame(8'hF4, 1'b1, 1'b0, 8'h00);

      run_frame(8'hED, 1'b1, 1'b1, 8'hAA);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
